// File: rtl/vc_arbiter.sv
// vc_arbiter
//   Weighted round-robin scheduler between the VC0/VC1 FIFOs and the D0/D1
//   output FIFOs. Each cycle at most one VC is granted. The granted VC is
//   popped through a combinational strobe. Its head word is routed to D0 or D1
//   on the following cycle through registered push/data outputs. A word is
//   only taken when its destination FIFO is not paused.
//
//   Build option: define STRICT_PRIO_VC0_EN to replace the weighted
//   round-robin with strict priority for VC0. In that build the weights are
//   ignored and owner is tied to 0.
//
// Ports
//   clk, reset_L             clock (posedge) / async active-low reset
//   enable                   0 blocks new pops (in-flight push still completes)
//   weight_vc0/weight_vc1    max consecutive grants per VC (0 behaves as 1)
//   vc0_empty/vc1_empty      VC FIFO empty flags
//   vc0_data/vc1_data        fall-through head words; bit DEST_BIT picks D0/D1
//   pause_d0/pause_d1        destination almost-full; blocks words to that FIFO
//   pop_vc0/pop_vc1          combinational pop strobes (never both high)
//   data_out                 registered routed word (holds when no push)
//   push_d0/push_d1          registered push strobes, one cycle after the grant
//   owner                    current round-robin owner (0=VC0, 1=VC1)
//   idle                     registered: both VCs empty and nothing granted

module vc_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_BIT   = 4,
  parameter int CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      weight_vc0,
  input  logic [CNT_W-1:0]      weight_vc1,
  input  logic                  vc0_empty,
  input  logic                  vc1_empty,
  input  logic [DATA_WIDTH-1:0] vc0_data,
  input  logic [DATA_WIDTH-1:0] vc1_data,
  input  logic                  pause_d0,
  input  logic                  pause_d1,
  output logic                  pop_vc0,
  output logic                  pop_vc1,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  push_d0,
  output logic                  push_d1,
  output logic                  owner,
  output logic                  idle
);

  localparam logic [CNT_W-1:0] W_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  // Arbitration state
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Output stage
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic                  idle_q, idle_d;

  // Combinational arbitration signals
  logic             dest0_s, dest1_s;
  logic             elig0_s, elig1_s;
  logic             grant0_s, grant1_s;
  logic             grant_any_s;
  logic             grant_vc_s;
  logic [CNT_W-1:0] w0_eff_s, w1_eff_s, w_sel_s;
  logic [CNT_W:0]   cnt_inc_s;

  assign dest0_s = vc0_data[DEST_BIT];
  assign dest1_s = vc1_data[DEST_BIT];

  // Eligibility: enabled, head word present, and destination not paused
  always_comb begin
    elig0_s = enable & ~vc0_empty & ~(dest0_s ? pause_d1 : pause_d0);
    elig1_s = enable & ~vc1_empty & ~(dest1_s ? pause_d1 : pause_d0);
  end

  // Grant selection; at most one VC per cycle
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
`ifdef STRICT_PRIO_VC0_EN
    grant0_s = elig0_s;
    grant1_s = elig1_s & ~elig0_s;
`else
    if (owner_q == 1'b0) begin
      grant0_s = elig0_s;
      grant1_s = elig1_s & ~elig0_s;
    end else begin
      grant1_s = elig1_s;
      grant0_s = elig0_s & ~elig1_s;
    end
`endif
  end

  assign grant_any_s = grant0_s | grant1_s;
  assign grant_vc_s  = grant1_s;

  // A zero weight behaves as a weight of one
  assign w0_eff_s = (weight_vc0 == {CNT_W{1'b0}}) ? W_ONE : weight_vc0;
  assign w1_eff_s = (weight_vc1 == {CNT_W{1'b0}}) ? W_ONE : weight_vc1;

  // Owner/burst-count next state
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    w_sel_s   = grant_vc_s ? w1_eff_s : w0_eff_s;
    // Grant to the owner extends its burst; grant to the other VC starts a new burst at 1
    cnt_inc_s = (grant_vc_s == owner_q) ? ({1'b0, cnt_q} + CNT_ONE) : CNT_ONE;
`ifdef STRICT_PRIO_VC0_EN
    owner_d = 1'b0;
    cnt_d   = {CNT_W{1'b0}};
`else
    if (grant_any_s) begin
      // Burst exhausted: hand ownership to the VC that was not just granted
      if (cnt_inc_s >= {1'b0, w_sel_s}) begin
        owner_d = ~grant_vc_s;
        cnt_d   = {CNT_W{1'b0}};
      end else begin
        owner_d = grant_vc_s;
        cnt_d   = cnt_inc_s[CNT_W-1:0];
      end
    end else begin
      owner_d = owner_q;
      cnt_d   = cnt_q;
    end
`endif
  end

  // Output-stage next state: capture granted word and its destination
  always_comb begin
    data_d    = data_q;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    if (grant0_s) begin
      data_d    = vc0_data;
      push_d0_d = ~dest0_s;
      push_d1_d = dest0_s;
    end else if (grant1_s) begin
      data_d    = vc1_data;
      push_d0_d = ~dest1_s;
      push_d1_d = dest1_s;
    end else begin
      data_d    = data_q;
      push_d0_d = 1'b0;
      push_d1_d = 1'b0;
    end
    idle_d = vc0_empty & vc1_empty & ~grant_any_s;
  end

  // State registers; reset discards any word popped in the reset cycle
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      owner_q   <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      data_q    <= {DATA_WIDTH{1'b0}};
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      idle_q    <= idle_d;
    end
  end

  // Pop strobes are gated by reset so a FIFO is never popped while held in reset
  assign pop_vc0  = grant0_s & reset_L;
  assign pop_vc1  = grant1_s & reset_L;
  assign data_out = data_q;
  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign owner    = owner_q;
  assign idle     = idle_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Testbench for vc_arbiter: directed cycles with expected pops/owner/idle
// checked inline, and expected pushes queued for a separate output monitor.

module tb_vc_arbiter;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       enable;
  logic [3:0] weight_vc0, weight_vc1;
  logic       vc0_empty, vc1_empty;
  logic [5:0] vc0_data, vc1_data;
  logic       pause_d0, pause_d1;
  logic       pop_vc0, pop_vc1;
  logic [5:0] data_out;
  logic       push_d0, push_d1;
  logic       owner, idle;

  typedef struct packed {
    logic [5:0] data;
    logic       dest;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  vc_arbiter dut (
    .clk(clk), .reset_L(reset_L), .enable(enable),
    .weight_vc0(weight_vc0), .weight_vc1(weight_vc1),
    .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
    .vc0_data(vc0_data), .vc1_data(vc1_data),
    .pause_d0(pause_d0), .pause_d1(pause_d1),
    .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
    .data_out(data_out), .push_d0(push_d0), .push_d1(push_d1),
    .owner(owner), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
  endtask

  // Monitor: every push the DUT presents must match the oldest queued expectation
  always @(negedge clk) begin
    if (push_d0 || push_d1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_push: got data %0h d0=%0b d1=%0b expected no push",
                 data_out, push_d0, push_d1);
      end else begin
        mon_e = sb_q.pop_front();
        check("push_data", {26'd0, data_out}, {26'd0, mon_e.data});
        check("push_d0", {31'd0, push_d0}, {31'd0, ~mon_e.dest});
        check("push_d1", {31'd0, push_d1}, {31'd0, mon_e.dest});
      end
    end
  end

  // One cycle: inputs already driven; check pops (and owner/idle when >= 0), queue expected push
  task automatic step(input logic ep0, input logic ep1, input int eo, input int ei, input string nm);
    exp_t e;
    @(negedge clk);
    check({nm, "_pop0"}, {31'd0, pop_vc0}, {31'd0, ep0});
    check({nm, "_pop1"}, {31'd0, pop_vc1}, {31'd0, ep1});
    if (eo >= 0) check({nm, "_owner"}, {31'd0, owner}, eo);
    if (ei >= 0) check({nm, "_idle"}, {31'd0, idle}, ei);
    if (ep0) begin
      e.data = vc0_data; e.dest = vc0_data[4];
      sb_q.push_back(e);
    end
    if (ep1) begin
      e.data = vc1_data; e.dest = vc1_data[4];
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_L = 1'b0; enable = 1'b1;
    weight_vc0 = 4'd2; weight_vc1 = 4'd1;
    vc0_empty = 1'b0; vc0_data = 6'h05;
    vc1_empty = 1'b1; vc1_data = 6'h00;
    pause_d0 = 1'b0; pause_d1 = 1'b0;

    // Reset state, with VC0 eligible so the pop gating is exercised
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pop0", {31'd0, pop_vc0}, 32'd0);
    check("rst_push_d0", {31'd0, push_d0}, 32'd0);
    check("rst_push_d1", {31'd0, push_d1}, 32'd0);
    check("rst_data", {26'd0, data_out}, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_idle", {31'd0, idle}, 32'd1);
    @(posedge clk); #1;
    reset_L = 1'b1;

    // Reset mid-burst: two VC0 grants (second flips owner to 1), then reset
    step(1'b1, 1'b0, 0, -1, "t1a");
    step(1'b1, 1'b0, 0, -1, "t1b");
    reset_L = 1'b0;
    @(negedge clk);
    check("t1_rst_pop0", {31'd0, pop_vc0}, 32'd0);
    check("t1_rst_push_d0", {31'd0, push_d0}, 32'd0);
    check("t1_rst_push_d1", {31'd0, push_d1}, 32'd0);
    check("t1_rst_owner", {31'd0, owner}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    reset_L = 1'b1;

`ifndef STRICT_PRIO_VC0_EN
    // Weighted round robin w0=2, w1=1, both VCs full, all to D0
    vc0_data = 6'h01; vc1_empty = 1'b0; vc1_data = 6'h02;
    step(1'b1, 1'b0, 0, -1, "t2_1");
    step(1'b1, 1'b0, 0, -1, "t2_2");
    step(1'b0, 1'b1, 1, -1, "t2_3");
    step(1'b1, 1'b0, 0, -1, "t2_4");
    step(1'b1, 1'b0, 0, 0, "t2_5");
    step(1'b0, 1'b1, 1, -1, "t2_6");
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step(1'b0, 1'b0, 0, 0, "t2_stop");
    step(1'b0, 1'b0, 0, 1, "t2_idle");

    // Pause on D1 blocks VC0 (head 6'h10), VC1 keeps flowing
    vc0_empty = 1'b0; vc0_data = 6'h10;
    vc1_empty = 1'b0; vc1_data = 6'h00; pause_d1 = 1'b1;
    step(1'b0, 1'b1, 0, -1, "t3_p1");
    step(1'b0, 1'b1, 0, -1, "t3_p2");
    pause_d1 = 1'b0;
    step(1'b1, 1'b0, 0, -1, "t3_go");
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step(1'b0, 1'b0, -1, -1, "t3_stop");
    @(negedge clk);
    check("t3_hold_data", {26'd0, data_out}, 32'h10);
    check("t3_hold_push_d1", {31'd0, push_d1}, 32'd0);
    @(posedge clk); #1;

    // Work-conserving: only VC1 has 3 words, w1=1
    weight_vc1 = 4'd1; vc1_empty = 1'b0;
    vc1_data = 6'h21; step(1'b0, 1'b1, -1, -1, "t4_1");
    vc1_data = 6'h32; step(1'b0, 1'b1, -1, -1, "t4_2");
    vc1_data = 6'h03; step(1'b0, 1'b1, -1, -1, "t4_3");
    vc1_empty = 1'b1;
    step(1'b0, 1'b0, -1, 0, "t4_drain");
    step(1'b0, 1'b0, -1, 1, "t4_idle");

    // Zero weight behaves as 1: w0=0, w1=3 -> VC0, VC1 x3, VC0
    weight_vc0 = 4'd0; weight_vc1 = 4'd3;
    vc0_empty = 1'b0; vc0_data = 6'h0a;
    vc1_empty = 1'b0; vc1_data = 6'h1b;
    step(1'b1, 1'b0, 0, -1, "tw_1");
    step(1'b0, 1'b1, 1, -1, "tw_2");
    step(1'b0, 1'b1, 1, -1, "tw_3");
    step(1'b0, 1'b1, 1, -1, "tw_4");
    step(1'b1, 1'b0, 0, -1, "tw_5");
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step(1'b0, 1'b0, 1, -1, "tw_stop");

    // Enable drops the cycle after a grant: in-flight push completes, no new pops
    weight_vc0 = 4'd2; weight_vc1 = 4'd1;
    vc0_empty = 1'b0; vc0_data = 6'h07;
    step(1'b1, 1'b0, 1, -1, "t5_grant");
    enable = 1'b0;
    step(1'b0, 1'b0, 0, -1, "t5_off1");
    step(1'b0, 1'b0, 0, -1, "t5_off2");
    enable = 1'b1;
    step(1'b1, 1'b0, 0, -1, "t5_on");
    vc0_empty = 1'b1;
    step(1'b0, 1'b0, 1, -1, "t5_stop");
`else
    // Strict priority: both VCs hold 4 words -> 4 VC0 pops then 4 VC1 pops
    weight_vc0 = 4'd1; weight_vc1 = 4'd1;
    for (int i = 0; i < 8; i++) begin
      vc0_empty = (i >= 4);
      vc0_data  = 6'(i);
      vc1_empty = 1'b0;
      vc1_data  = 6'(8'h18 + i);
      step(i < 4, i >= 4, 0, -1, "t6");
    end
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step(1'b0, 1'b0, 0, -1, "t6_stop");
`endif

    // Drain and confirm every expected push was seen
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    step(1'b0, 1'b0, -1, -1, "drain1");
    step(1'b0, 1'b0, -1, -1, "drain2");
    check("sb_empty", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
